rf_writeback_queue: RTL and testbench

Write-side initiator for the processor's 32x32 register file. It accepts register write requests from two producers (a single-cycle execute path and a slower load/multi-cycle path), buffers them in a small in-order FIFO, and drives the register file write port (WE3, A3, WD3) with at most one write per cycle. It also provides a combinational lookup, so decode can forward values that are queued but not yet written.

---
 rtl/rf_writeback_queue.sv | 101 ++++++++++
 tb/tb_rf_writeback_queue.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/rf_writeback_queue.sv
// Two-producer register-file writeback queue. S0 wins over S1. The queue drains in
// order through a registered WE3/A3/WD3 port, and it provides a forwarding lookup.
module rf_writeback_queue #(
  parameter int width = 5,
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       S0_VALID,
  output logic                       S0_READY,
  input  logic [width-1:0]           S0_ADDR,
  input  logic [31:0]                S0_DATA,
  input  logic                       S1_VALID,
  output logic                       S1_READY,
  input  logic [width-1:0]           S1_ADDR,
  input  logic [31:0]                S1_DATA,
  input  logic                       STALL,
  output logic                       WE3,
  output logic [width-1:0]           A3,
  output logic [31:0]                WD3,
  input  logic [width-1:0]           LK_ADDR,
  output logic                       LK_HIT,
  output logic [31:0]                LK_DATA,
  output logic                       FULL,
  output logic                       EMPTY,
  output logic [$clog2(DEPTH+1)-1:0] COUNT
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [width-1:0] q_addr [DEPTH];
  logic [31:0]      q_data [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, idx;
  logic [CW-1:0]    cnt;
  logic [width-1:0] in_addr;
  logic [31:0]      in_data;
  logic             acc, push, pop;

  assign FULL     = (cnt == CW'(DEPTH));
  assign EMPTY    = (cnt == '0);
  assign COUNT    = cnt;
  assign S0_READY = !FULL;
  assign S1_READY = !FULL && !S0_VALID;
  assign acc      = (S0_VALID && S0_READY) || (S1_VALID && S1_READY);
  assign in_addr  = S0_VALID ? S0_ADDR : S1_ADDR;
  assign in_data  = S0_VALID ? S0_DATA : S1_DATA;
  // Writes to r0 complete the handshake but are dropped; r0 reads as zero anyway.
  assign push     = acc && (in_addr != '0);
  assign pop      = !STALL && !EMPTY;

  always_ff @(posedge CLK) begin
    if (push) begin
      q_addr[wr_ptr] <= in_addr;
      q_data[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      WE3    <= 1'b0;
      A3     <= '0;
      WD3    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        WE3    <= 1'b1;
        A3     <= q_addr[rd_ptr];
        WD3    <= q_data[rd_ptr];
      end else begin
        WE3    <= 1'b0;
      end
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  // Scan from oldest (output register) to youngest (tail); later matches override.
  always_comb begin
    LK_HIT  = 1'b0;
    LK_DATA = '0;
    idx     = '0;
    if (WE3 && A3 == LK_ADDR) begin
      LK_HIT  = 1'b1;
      LK_DATA = WD3;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (CW'(i) < cnt && q_addr[idx] == LK_ADDR) begin
        LK_HIT  = 1'b1;
        LK_DATA = q_data[idx];
      end
    end
    if (LK_ADDR == '0) begin
      LK_HIT  = 1'b0;
      LK_DATA = '0;
    end
  end
endmodule

// File: tb/tb_rf_writeback_queue.sv
// Randomized and directed bench for rf_writeback_queue. A queue-based reference model
// predicts the writes, and a separate negedge monitor pops and checks them.
module tb_rf_writeback_queue;
  localparam int DEPTH = 4;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  logic        CLK, RST_N;
  logic        S0_VALID, S0_READY, S1_VALID, S1_READY, STALL;
  logic [4:0]  S0_ADDR, S1_ADDR, A3, LK_ADDR;
  logic [31:0] S0_DATA, S1_DATA, WD3, LK_DATA;
  logic        WE3, LK_HIT, FULL, EMPTY;
  logic [2:0]  COUNT;

  rf_writeback_queue #(.width(5), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .S0_VALID(S0_VALID), .S0_READY(S0_READY), .S0_ADDR(S0_ADDR), .S0_DATA(S0_DATA),
    .S1_VALID(S1_VALID), .S1_READY(S1_READY), .S1_ADDR(S1_ADDR), .S1_DATA(S1_DATA),
    .STALL(STALL), .WE3(WE3), .A3(A3), .WD3(WD3),
    .LK_ADDR(LK_ADDR), .LK_HIT(LK_HIT), .LK_DATA(LK_DATA),
    .FULL(FULL), .EMPTY(EMPTY), .COUNT(COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int   n_checks = 0;
  int   n_fail   = 0;
  ent_t mq[$];     // entries waiting in the queue, oldest first
  ent_t exp_q[$];  // writes the monitor should observe, in order
  logic        out_we = 1'b0;
  logic [4:0]  out_a  = '0;
  logic [31:0] out_d  = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // The youngest pending value for an address wins. The output register counts only while it is writing.
  task automatic mlook(input logic [4:0] a, output logic h, output logic [31:0] d);
    h = 1'b0;
    d = '0;
    if (a != 0) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (mq[i].a == a) begin
          h = 1'b1;
          d = mq[i].d;
          break;
        end
      end
      if (!h && out_we && out_a == a) begin
        h = 1'b1;
        d = out_d;
      end
    end
  endtask

  // Called just after a rising edge. It drives one cycle, checks at the negedge and advances the model.
  task automatic cycle(input logic s0v, input logic [4:0] s0a, input logic [31:0] s0d,
                       input logic s1v, input logic [4:0] s1a, input logic [31:0] s1d,
                       input logic stl, input logic [4:0] lk);
    logic        mfull, h, acc;
    logic [31:0] d;
    ent_t        e;
    S0_VALID = s0v; S0_ADDR = s0a; S0_DATA = s0d;
    S1_VALID = s1v; S1_ADDR = s1a; S1_DATA = s1d;
    STALL = stl; LK_ADDR = lk;
    @(negedge CLK);
    mfull = (mq.size() == DEPTH);
    mlook(lk, h, d);
    chk("s0_ready", S0_READY, !mfull);
    chk("s1_ready", S1_READY, !mfull && !s0v);
    chk("count", COUNT, mq.size());
    chk("full", FULL, mfull);
    chk("empty", EMPTY, mq.size() == 0);
    chk("we3", WE3, out_we);
    chk("a3", A3, out_a);
    chk("wd3", WD3, out_d);
    chk("lk_hit", LK_HIT, h);
    chk("lk_data", LK_DATA, d);
    @(posedge CLK);
    acc = !mfull && (s0v || s1v);
    if (!stl && mq.size() > 0) begin
      e = mq.pop_front();
      exp_q.push_back(e);
      out_we = 1'b1; out_a = e.a; out_d = e.d;
    end else begin
      out_we = 1'b0;
    end
    if (acc) begin
      e.a = s0v ? s0a : s1a;
      e.d = s0v ? s0d : s1d;
      if (e.a != 0) mq.push_back(e);
    end
    #1;
  endtask

  task automatic idle(input int n, input logic stl);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, stl, 5'd7);
  endtask

  always @(negedge CLK) begin
    ent_t e;
    if (RST_N && WE3) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got A3=%0h WD3=%0h expected no write", A3, WD3);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", A3, e.a);
        chk("wr_data", WD3, e.d);
      end
    end
  end

  initial begin
    RST_N = 1'b0;
    S0_VALID = 0; S0_ADDR = 0; S0_DATA = 0;
    S1_VALID = 0; S1_ADDR = 0; S1_DATA = 0;
    STALL = 0; LK_ADDR = 0;
    #2;
    chk("rst_we3", WE3, 0);
    chk("rst_count", COUNT, 0);
    chk("rst_empty", EMPTY, 1);
    chk("rst_full", FULL, 0);
    @(posedge CLK); #1 RST_N = 1'b1;

    // Single write
    cycle(1, 5'd5, 32'hAB, 0, 0, 0, 0, 5'd5);
    idle(2, 0);
    // Priority and ordering
    cycle(1, 5'd3, 32'h11, 1, 5'd4, 32'h22, 0, 5'd3);
    cycle(0, 0, 0, 1, 5'd4, 32'h22, 0, 5'd4);
    idle(3, 0);
    // Full and stall
    for (int i = 0; i < 4; i++) cycle(1, 5'(10 + i), 32'h100 + i, 0, 0, 0, 1, 5'd11);
    cycle(1, 5'd20, 32'hDEAD, 0, 0, 0, 1, 5'd20);
    idle(6, 0);
    // Register 0
    cycle(0, 0, 0, 1, 5'd0, 32'hFFFF_FFFF, 0, 5'd0);
    idle(2, 0);
    // Forwarding: the youngest value wins, and a miss reads zero
    cycle(1, 5'd7, 32'h1, 0, 0, 0, 1, 5'd7);
    cycle(1, 5'd7, 32'h2, 0, 0, 0, 1, 5'd7);
    cycle(0, 0, 0, 0, 0, 0, 1, 5'd7);
    cycle(0, 0, 0, 0, 0, 0, 1, 5'd8);
    idle(4, 0);
    // Mid-cycle reset with three entries queued
    for (int i = 0; i < 3; i++) cycle(1, 5'(1 + i), 32'h50 + i, 0, 0, 0, 1, 5'd1);
    #2 RST_N = 1'b0;
    #1;
    chk("mid_rst_we3", WE3, 0);
    chk("mid_rst_a3", A3, 0);
    chk("mid_rst_wd3", WD3, 0);
    chk("mid_rst_count", COUNT, 0);
    chk("mid_rst_empty", EMPTY, 1);
    mq.delete(); exp_q.delete();
    out_we = 0; out_a = 0; out_d = 0;
    @(posedge CLK); #1 RST_N = 1'b1;
    idle(4, 0);
    // Random traffic
    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(0, 9) < 4, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 9) < 5, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 9) < 3, 5'($urandom_range(0, 8)));
    end
    idle(8, 0);
    chk("drained_model", mq.size(), 0);
    chk("drained_writes", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
